eth_tx_feeder: RTL and testbench



---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_tx_feeder_if.sv | 14 +
 rtl/frame_ram.sv | 36 +++
 rtl/eth_tx_feeder.sv | 153 +++++++++++++++
 tb/tb_eth_tx_feeder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet transmit path.
package eth_pkg;

    localparam int MAX_PAYLOAD = 1500;
    localparam int MIN_PAYLOAD = 46;
    localparam int LEN_W       = 11;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LAUNCH  = 2'd1,
        STREAM  = 2'd2,
        HOLDOFF = 2'd3
    } feeder_state_t;

    // Stored frame length: one past the final write pointer, saturated at the buffer depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] wr_ptr,
                                                   input logic [LEN_W-1:0] max_len);
        logic [LEN_W-1:0] len_s;
        if (wr_ptr < max_len) begin
            len_s = wr_ptr + LEN_W'(1);
        end else begin
            len_s = max_len;
        end
        return len_s;
    endfunction

endpackage

// File: rtl/eth_tx_feeder_if.sv
// Ingress byte stream carrying one payload frame plus its destination and ethertype.
interface eth_tx_feeder_if;

    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [47:0] s_dest;
    logic [15:0] s_type;

    modport master (output s_valid, s_data, s_last, s_dest, s_type, input s_ready);
    modport slave  (input s_valid, s_data, s_last, s_dest, s_type, output s_ready);

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port byte buffer: synchronous write, registered one-cycle read.
module frame_ram
    import eth_pkg::*;
#(
    parameter int DEPTH = MAX_PAYLOAD,
    parameter int AW    = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; the output register is cleared so the byte lane idles at zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'd0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/eth_tx_feeder.sv
// Store-and-forward feeder: buffers one whole payload frame, then streams it to the
// transmit MAC one byte per send_next cycle, followed by a fixed idle hold-off.
module eth_tx_feeder
    import eth_pkg::*;
#(
    parameter int MAX_LEN = MAX_PAYLOAD,
    parameter int HOLDOFF = 160
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_tx_feeder_if.slave        s,
    input  logic                  send_next,
    output logic                  mac_phy_txen,
    output logic [7:0]            mac_phy_txd,
    output logic [47:0]           mac_dest,
    output logic [15:0]           ethertype,
    output logic                  busy,
    output logic                  err_oversize
);

    localparam int                HOLD_W    = $clog2(HOLDOFF);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    feeder_state_t     state_r;
    logic [LEN_W-1:0]  wr_ptr_r;
    logic [LEN_W-1:0]  rd_ptr_r;
    logic [LEN_W-1:0]  len_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              ovf_r;
    logic              s_ready_r;
    logic              txen_r;
    logic              busy_r;
    logic              err_r;
    logic [47:0]       dest_r;
    logic [15:0]       type_r;
    logic              accept_s;
    logic              room_s;
    logic              wr_en_s;
    logic              rd_en_s;

    assign accept_s = s.s_valid & s_ready_r;
    assign room_s   = (wr_ptr_r < MAX_LEN_L);
    assign wr_en_s  = accept_s & room_s;

    // RAM read strobe; the read address is always the current read pointer (0 in LAUNCH).
    always_comb begin
        rd_en_s = 1'b0;
        case (state_r)
            LAUNCH:  rd_en_s = send_next;
            STREAM:  rd_en_s = send_next & (rd_ptr_r < len_r);
            default: rd_en_s = 1'b0;
        endcase
    end

    // Frame sequencing: fill, launch, stream, hold-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FILL;
            wr_ptr_r   <= LEN_W'(0);
            rd_ptr_r   <= LEN_W'(0);
            len_r      <= LEN_W'(0);
            hold_cnt_r <= HOLD_W'(0);
            ovf_r      <= 1'b0;
            s_ready_r  <= 1'b0;
            txen_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            dest_r     <= 48'd0;
            type_r     <= 16'd0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                FILL: begin
                    s_ready_r <= 1'b1;
                    if (accept_s) begin
                        if (wr_ptr_r == LEN_W'(0)) begin
                            dest_r <= s.s_dest;
                            type_r <= s.s_type;
                        end
                        if (room_s) begin
                            wr_ptr_r <= wr_ptr_r + LEN_W'(1);
                        end else begin
                            ovf_r <= 1'b1;
                        end
                        if (s.s_last) begin
                            len_r     <= clamp_len(wr_ptr_r, MAX_LEN_L);
                            err_r     <= ovf_r | ~room_s;
                            ovf_r     <= 1'b0;
                            s_ready_r <= 1'b0;
                            txen_r    <= 1'b1;
                            busy_r    <= 1'b1;
                            state_r   <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    if (send_next) begin
                        rd_ptr_r <= LEN_W'(1);
                        state_r  <= STREAM;
                    end
                end
                STREAM: begin
                    // send_next low here means the MAC hit its own length limit.
                    if (send_next && (rd_ptr_r < len_r)) begin
                        rd_ptr_r <= rd_ptr_r + LEN_W'(1);
                    end else begin
                        txen_r  <= 1'b0;
                        state_r <= eth_pkg::HOLDOFF;
                    end
                end
                eth_pkg::HOLDOFF: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r <= HOLD_W'(0);
                        wr_ptr_r   <= LEN_W'(0);
                        rd_ptr_r   <= LEN_W'(0);
                        len_r      <= LEN_W'(0);
                        s_ready_r  <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= FILL;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    txen_r    <= 1'b0;
                    s_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= FILL;
                end
            endcase
        end
    end

    frame_ram #(.DEPTH(MAX_LEN), .AW(LEN_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata (s.s_data),
        .re    (rd_en_s),
        .raddr (rd_ptr_r),
        .rdata (mac_phy_txd)
    );

    assign s.s_ready    = s_ready_r;
    assign mac_phy_txen = txen_r;
    assign mac_dest     = dest_r;
    assign ethertype    = type_r;
    assign busy         = busy_r;
    assign err_oversize = err_r;

endmodule

// File: tb/tb_eth_tx_feeder.sv
// Directed bench for eth_tx_feeder with a minimal MAC-side send_next model.
module tb_eth_tx_feeder;
    import eth_pkg::*;

    localparam int HOLD_CYC = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_next;
    logic        mac_phy_txen;
    logic [7:0]  mac_phy_txd;
    logic [47:0] mac_dest;
    logic [15:0] ethertype;
    logic        busy;
    logic        err_oversize;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          rdy_busy_cnt = 0;
    int          fall_cyc = 0;
    bit          tmo = 1'b0;
    logic [7:0]  got_q[$];
    logic [47:0] cap_dest;
    logic [15:0] cap_type;

    always #5 clk = ~clk;

    eth_tx_feeder_if s_if();

    eth_tx_feeder #(.MAX_LEN(MAX_PAYLOAD), .HOLDOFF(HOLD_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (s_if),
        .send_next    (send_next),
        .mac_phy_txen (mac_phy_txen),
        .mac_phy_txd  (mac_phy_txd),
        .mac_dest     (mac_dest),
        .ethertype    (ethertype),
        .busy         (busy),
        .err_oversize (err_oversize)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && err_oversize) err_cnt <= err_cnt + 1;
        if (!rst && s_if.s_ready && busy) rdy_busy_cnt <= rdy_busy_cnt + 1;
    end

    // Offer n bytes (base+i); header fields differ from the first-beat values on later beats.
    task automatic send_frame(input int n, input int base, input logic [47:0] dest,
                              input logic [15:0] typ, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                s_if.s_valid = 1'b0;
                @(negedge clk);
            end
            s_if.s_valid = 1'b1;
            s_if.s_data  = 8'(base + i);
            s_if.s_last  = (i == n - 1);
            s_if.s_dest  = (i == 0) ? dest : ~dest;
            s_if.s_type  = (i == 0) ? typ : ~typ;
            for (int g = 0; g < 2000 && !s_if.s_ready; g++) @(negedge clk);
            if (!s_if.s_ready) tmo = 1'b1;
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    // MAC model: wait for txen, spend hdr header cycles, then collect payload bytes while txen holds.
    task automatic mac_take(input int hdr);
        got_q.delete();
        for (int g = 0; g < 4000 && !mac_phy_txen; g++) @(negedge clk);
        if (!mac_phy_txen) tmo = 1'b1;
        repeat (hdr) @(negedge clk);
        send_next = 1'b1;
        @(negedge clk);
        cap_dest = mac_dest;
        cap_type = ethertype;
        for (int g = 0; g < 1600 && mac_phy_txen; g++) begin
            got_q.push_back(mac_phy_txd);
            @(negedge clk);
        end
        if (mac_phy_txen) tmo = 1'b1;
        fall_cyc  = cyc;
        send_next = 1'b0;
    endtask

    task automatic wait_ready;
        for (int g = 0; g < 400 && !s_if.s_ready; g++) @(negedge clk);
        if (!s_if.s_ready) tmo = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_if.s_ready, mac_phy_txen, mac_phy_txd, mac_dest, ethertype, busy, err_oversize} !== 76'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b txen=%b txd=%h dest=%h type=%h busy=%b err=%b want all 0",
                     s_if.s_ready, mac_phy_txen, mac_phy_txd, mac_dest, ethertype, busy, err_oversize);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_if.s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill got rdy=%b busy=%b want rdy=1 busy=0", s_if.s_ready, busy);
        end
    endtask

    task automatic test_frame64;
        send_frame(64, 0, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0);
        checks++;
        if (mac_phy_txen !== 1'b1 || s_if.s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL launch_latency got txen=%b rdy=%b busy=%b want 1 0 1", mac_phy_txen, s_if.s_ready, busy);
        end
        mac_take(8);
        checks++;
        if (got_q.size() !== 64) begin
            errors++;
            $display("FAIL f64_len got %0d want 64", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL f64_byte[%0d] got %h want %h", i, got_q[i], 8'(i));
            end
        end
        checks++;
        if (cap_dest !== 48'h0A0B0C0D0E0F || cap_type !== 16'h0800) begin
            errors++;
            $display("FAIL f64_hdr got %h/%h want 0a0b0c0d0e0f/0800", cap_dest, cap_type);
        end
        wait_ready();
        checks++;
        if (cyc - fall_cyc !== HOLD_CYC) begin
            errors++;
            $display("FAIL holdoff_gap got %0d want %0d", cyc - fall_cyc, HOLD_CYC);
        end
        checks++;
        if (err_cnt !== 0) begin
            errors++;
            $display("FAIL f64_no_err got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_one_byte;
        send_frame(1, 8'hA5, 48'h112233445566, 16'h86DD, 1'b0);
        mac_take(4);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL one_byte got n=%0d b=%h want n=1 b=a5", got_q.size(), got_q[0]);
        end
        send_frame(1, 8'h5A, 48'h112233445566, 16'h86DD, 1'b0);
        checks++;
        if (cyc - fall_cyc !== HOLD_CYC + 1 || mac_phy_txen !== 1'b1) begin
            errors++;
            $display("FAIL relaunch_gap got %0d txen=%b want %0d txen=1", cyc - fall_cyc, mac_phy_txen, HOLD_CYC + 1);
        end
        mac_take(4);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL one_byte2 got n=%0d b=%h want n=1 b=5a", got_q.size(), got_q[0]);
        end
        wait_ready();
    endtask

    task automatic test_oversize;
        int e0;
        e0 = err_cnt;
        send_frame(1502, 0, 48'hFFEEDDCCBBAA, 16'h0806, 1'b0);
        checks++;
        if (err_oversize !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse got %b want 1", err_oversize);
        end
        @(negedge clk);
        checks++;
        if (err_oversize !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle got %b want 0", err_oversize);
        end
        mac_take(8);
        checks++;
        if (got_q.size() !== MAX_PAYLOAD) begin
            errors++;
            $display("FAIL ovs_len got %0d want %0d", got_q.size(), MAX_PAYLOAD);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL ovs_byte[%0d] got %h want %h", i, got_q[i], 8'(i));
            end
        end
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL ovs_pulses got %0d want 1", err_cnt - e0);
        end
        wait_ready();
    endtask

    task automatic test_back_to_back;
        logic [7:0]  qa[$];
        logic [47:0] da;
        logic [15:0] ta;
        int          r0;
        r0 = rdy_busy_cnt;
        fork
            begin
                send_frame(10, 8'h10, 48'h010203040506, 16'h1111, 1'b0);
                send_frame(5, 8'h80, 48'hA1A2A3A4A5A6, 16'h2222, 1'b0);
            end
            begin
                mac_take(6);
                qa = got_q;
                da = cap_dest;
                ta = cap_type;
                mac_take(6);
            end
        join
        checks++;
        if (qa.size() !== 10 || da !== 48'h010203040506 || ta !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_first got n=%0d dest=%h type=%h want 10 010203040506 1111", qa.size(), da, ta);
        end
        for (int i = 0; i < qa.size(); i++) begin
            checks++;
            if (qa[i] !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL b2b_a[%0d] got %h want %h", i, qa[i], 8'(8'h10 + i));
            end
        end
        checks++;
        if (got_q.size() !== 5 || cap_dest !== 48'hA1A2A3A4A5A6 || cap_type !== 16'h2222) begin
            errors++;
            $display("FAIL b2b_second got n=%0d dest=%h type=%h want 5 a1a2a3a4a5a6 2222", got_q.size(), cap_dest, cap_type);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(8'h80 + i)) begin
                errors++;
                $display("FAIL b2b_b[%0d] got %h want %h", i, got_q[i], 8'(8'h80 + i));
            end
        end
        wait_ready();
        checks++;
        if (rdy_busy_cnt !== r0) begin
            errors++;
            $display("FAIL b2b_ready_low got %0d ready-while-busy cycles want 0", rdy_busy_cnt - r0);
        end
    endtask

    task automatic test_toggle;
        send_frame(20, 8'h30, 48'h0000000000AB, 16'h0801, 1'b1);
        mac_take(3);
        checks++;
        if (got_q.size() !== 20) begin
            errors++;
            $display("FAIL tog_len got %0d want 20", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(8'h30 + i)) begin
                errors++;
                $display("FAIL tog_byte[%0d] got %h want %h", i, got_q[i], 8'(8'h30 + i));
            end
        end
        wait_ready();
    endtask

    task automatic test_reset_mid;
        send_frame(40, 8'h40, 48'h0C0C0C0C0C0C, 16'h0C0C, 1'b0);
        repeat (3) @(negedge clk);
        send_next = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_if.s_ready, mac_phy_txen, mac_phy_txd, mac_dest, ethertype, busy, err_oversize} !== 76'd0) begin
            errors++;
            $display("FAIL midrst_outputs got rdy=%b txen=%b txd=%h dest=%h type=%h busy=%b err=%b want all 0",
                     s_if.s_ready, mac_phy_txen, mac_phy_txd, mac_dest, ethertype, busy, err_oversize);
        end
        send_next = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        send_frame(60, 8'hC0, 48'h3C3C3C3C3C3C, 16'h88B5, 1'b0);
        mac_take(5);
        checks++;
        if (got_q.size() !== 60 || cap_dest !== 48'h3C3C3C3C3C3C || cap_type !== 16'h88B5) begin
            errors++;
            $display("FAIL midrst_frame got n=%0d dest=%h type=%h want 60 3c3c3c3c3c3c 88b5", got_q.size(), cap_dest, cap_type);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(8'hC0 + i)) begin
                errors++;
                $display("FAIL midrst_byte[%0d] got %h want %h", i, got_q[i], 8'(8'hC0 + i));
            end
        end
        wait_ready();
    endtask

    initial begin
        rst          = 1'b1;
        send_next    = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'd0;
        s_if.s_last  = 1'b0;
        s_if.s_dest  = 48'd0;
        s_if.s_type  = 16'd0;
        test_reset();
        test_frame64();
        test_one_byte();
        test_oversize();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeouts got %b want 0", tmo);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
